// File: rtl/ym6046_multi.sv
// ym6046_multi: parametrised pad I/O controller with per-pin direction,
// output latches, synchronised inputs and a maskable TH-edge interrupt.
`timescale 1ns/1ps
module ym6046_multi #(
    parameter int PORTS       = 3,
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   MCLK,
    input  logic                   SRES,
    input  logic                   CS,
    input  logic                   WE,
    input  logic [3:0]             ADDR,
    input  logic [7:0]             WDATA,
    output logic [7:0]             RDATA,
    input  logic [PORTS*WIDTH-1:0] PORT_i,
    output logic [PORTS*WIDTH-1:0] PORT_o,
    output logic [PORTS*WIDTH-1:0] PORT_d,
    output logic                   HL
);

    localparam int N  = PORTS * WIDTH;
    localparam int TH = WIDTH - 1;
    localparam logic [7:0] PIN_MASK = 8'((9'd1 << WIDTH) - 9'd1);
    localparam logic [7:0] VERSION  = {1'b0, 3'(PORTS), 4'h1};

    logic [7:0]       latch_q [PORTS];
    logic [7:0]       ctrl_q  [PORTS];
    logic [7:0]       view    [PORTS];
    logic [N-1:0]     sync_q  [SYNC_STAGES];
    logic [N-1:0]     sync_in;
    logic [PORTS-1:0] th_now;
    logic [PORTS-1:0] th_prev_q;
    logic [PORTS-1:0] th_fall;
    logic [PORTS-1:0] pend_q;
    logic [PORTS-1:0] pend_d;
    logic [PORTS-1:0] inten;
    logic [PORTS-1:0] data_sel;
    logic [PORTS-1:0] ctrl_sel;
    logic [7:0]       rd_mux;
    logic             wr;
    logic             rd;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign wr      = CS & WE;
    assign rd      = CS & ~WE;

    // Output pins show the latch; input pins show the synchronised pad.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [7:0] pins;
        assign pins = 8'(sync_in[p*WIDTH +: WIDTH]);
        assign view[p] = (latch_q[p] & (ctrl_q[p] | ~PIN_MASK))
                       | (pins & ~ctrl_q[p] & PIN_MASK);
        assign PORT_o[p*WIDTH +: WIDTH] = latch_q[p][WIDTH-1:0];
        assign PORT_d[p*WIDTH +: WIDTH] = ~ctrl_q[p][WIDTH-1:0];
    end

    always_comb begin
        data_sel = '0;
        ctrl_sel = '0;
        th_now   = '0;
        th_fall  = '0;
        pend_d   = '0;
        inten    = '0;
        rd_mux   = 8'h00;
        if (ADDR == 4'd0) rd_mux = VERSION;
        for (int p = 0; p < PORTS; p++) begin
            data_sel[p] = (ADDR == 4'(p + 1));
            ctrl_sel[p] = (ADDR == 4'(PORTS + 1 + p));
            th_now[p]   = sync_in[p*WIDTH + TH];
            inten[p]    = ctrl_q[p][7];
            th_fall[p]  = th_prev_q[p] & ~th_now[p] & ~ctrl_q[p][TH];
            // A fresh edge outranks a clear in the same cycle.
            pend_d[p]   = th_fall[p]
                        | (pend_q[p]
                           & ~(rd & data_sel[p])
                           & ~(wr & ctrl_sel[p] & ~WDATA[7]));
            if (data_sel[p]) rd_mux = view[p];
            if (ctrl_sel[p]) rd_mux = ctrl_q[p];
        end
    end

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            for (int p = 0; p < PORTS; p++) begin
                latch_q[p] <= '0;
                ctrl_q[p]  <= '0;
            end
            // Synchroniser idles high so release never looks like a TH fall.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
            th_prev_q <= '1;
            pend_q    <= '0;
            HL        <= 1'b1;
            RDATA     <= 8'h00;
        end else begin
            sync_q[0] <= PORT_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            th_prev_q <= th_now;
            pend_q    <= pend_d;
            HL        <= ~|(pend_q & inten);
            for (int p = 0; p < PORTS; p++) begin
                if (wr && data_sel[p]) latch_q[p] <= WDATA;
                if (wr && ctrl_sel[p]) ctrl_q[p]  <= WDATA;
            end
            if (rd) RDATA <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ym6046_multi.sv
// Bench for ym6046_multi: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model; 7x8 parameter sweep.
`timescale 1ns/1ps
module tb_ym6046_multi;

    localparam int P  = 3;
    localparam int W  = 7;
    localparam int S  = 2;
    localparam int N  = P * W;
    localparam int P7 = 7;
    localparam int W7 = 8;
    localparam int N7 = P7 * W7;

    logic         MCLK = 1'b0;
    logic         SRES = 1'b0;
    logic         CS = 1'b0, WE = 1'b0;
    logic [3:0]   ADDR = '0;
    logic [7:0]   WDATA = '0;
    logic [7:0]   RDATA;
    logic [N-1:0] PORT_i = '1;
    logic [N-1:0] PORT_o, PORT_d;
    logic         HL;

    logic          CS7 = 1'b0, WE7 = 1'b0;
    logic [3:0]    ADDR7 = '0;
    logic [7:0]    WDATA7 = '0;
    logic [7:0]    RD7;
    logic [N7-1:0] PI7 = '1;
    logic [N7-1:0] PO7, PD7;
    logic          HL7;

    always #5 MCLK = ~MCLK;

    ym6046_multi #(.PORTS(P), .WIDTH(W), .SYNC_STAGES(S)) dut (
        .MCLK(MCLK), .SRES(SRES), .CS(CS), .WE(WE), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .PORT_i(PORT_i),
        .PORT_o(PORT_o), .PORT_d(PORT_d), .HL(HL)
    );

    ym6046_multi #(.PORTS(P7), .WIDTH(W7), .SYNC_STAGES(S)) dut7 (
        .MCLK(MCLK), .SRES(SRES), .CS(CS7), .WE(WE7), .ADDR(ADDR7),
        .WDATA(WDATA7), .RDATA(RD7), .PORT_i(PI7),
        .PORT_o(PO7), .PORT_d(PD7), .HL(HL7)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural model: pv[k] is the pad vector sampled k edges ago.
    logic [7:0]   m_latch [P];
    logic [7:0]   m_ctrl  [P];
    bit           m_pend  [P];
    bit           n_pend  [P];
    logic         m_hl;
    logic [7:0]   m_rd;
    logic [N-1:0] pv [S+1];
    bit           m_valid = 0;
    bit           any_irq;
    bit           fall;
    bit           clr;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int ai;
        int p;
        logic [7:0] v;
        ai = int'(a);
        v  = 8'h00;
        if (ai == 0) begin
            v = 8'((P << 4) | 1);
        end else if (ai <= P) begin
            p = ai - 1;
            for (int b = 0; b < 8; b++) begin
                if (b < W && !m_ctrl[p][b])
                    v[b] = pv[S-1][p*W + b];
                else
                    v[b] = m_latch[p][b];
            end
        end else if (ai <= 2 * P) begin
            v = m_ctrl[ai - P - 1];
        end
        return v;
    endfunction

    always @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            for (int p = 0; p < P; p++) begin
                m_latch[p] = 8'h00;
                m_ctrl[p]  = 8'h00;
                m_pend[p]  = 0;
            end
            for (int k = 0; k <= S; k++) pv[k] = '1;
            m_hl    = 1'b1;
            m_rd    = 8'h00;
            m_valid = 1;
        end else begin
            any_irq = 0;
            for (int p = 0; p < P; p++)
                if (m_pend[p] && m_ctrl[p][7]) any_irq = 1;
            if (CS && !WE) m_rd = m_read(ADDR);
            for (int p = 0; p < P; p++) begin
                fall = pv[S][p*W + W-1] && !pv[S-1][p*W + W-1]
                       && !m_ctrl[p][W-1];
                clr  = (CS && !WE && int'(ADDR) == p + 1)
                    || (CS && WE && int'(ADDR) == P + 1 + p && !WDATA[7]);
                n_pend[p] = fall || (m_pend[p] && !clr);
            end
            for (int p = 0; p < P; p++) begin
                m_pend[p] = n_pend[p];
                if (CS && WE && int'(ADDR) == p + 1)     m_latch[p] = WDATA;
                if (CS && WE && int'(ADDR) == P + 1 + p) m_ctrl[p]  = WDATA;
            end
            m_hl = !any_irq;
            for (int k = S; k > 0; k--) pv[k] = pv[k-1];
            pv[0] = PORT_i;
        end
    end

    logic [N-1:0] exp_o, exp_d;

    always @(negedge MCLK) begin
        if (m_valid) begin
            exp_o = '0;
            exp_d = '0;
            for (int p = 0; p < P; p++)
                for (int b = 0; b < W; b++) begin
                    exp_o[p*W + b] = m_latch[p][b];
                    exp_d[p*W + b] = !m_ctrl[p][b];
                end
            chk("rdata",  RDATA,  m_rd);
            chk("hl",     HL,     m_hl);
            chk("port_o", PORT_o, exp_o);
            chk("port_d", PORT_d, exp_d);
        end
    end

    task automatic tick();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        CS = 1; WE = 1; ADDR = a; WDATA = d;
        tick();
        CS = 0; WE = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        CS = 1; WE = 0; ADDR = a;
        tick();
        CS = 0;
        v = RDATA;
    endtask

    task automatic rd7(input logic [3:0] a, output logic [7:0] v);
        CS7 = 1; WE7 = 0; ADDR7 = a;
        tick();
        CS7 = 0;
        v = RD7;
    endtask

    logic [7:0] v;
    logic [7:0] e;
    int         k;

    initial begin
        // Reset held with pads toggling
        repeat (4) begin
            PORT_i = N'($urandom);
            PI7    = {$urandom, $urandom};
            tick();
            chk("rst_port_d", PORT_d, {N{1'b1}});
            chk("rst_port_o", PORT_o, {N{1'b0}});
            chk("rst_hl",     HL,     1'b1);
            chk("rst_rdata",  RDATA,  8'h00);
        end
        PORT_i = '1;
        PI7    = '1;
        #1 SRES = 1;
        tick();
        rd(4'd0, v);
        chk("version", v, 8'h31);

        // Direction mux
        wr(4'd4, 8'h40);
        wr(4'd1, 8'hFF);
        PORT_i[6:0] = 7'h15;
        repeat (S) tick();
        rd(4'd1, v);
        chk("dir_mux", v, 8'hD5);

        // TH interrupt on port 1 (pad bit 13)
        wr(4'd5, 8'h80);
        repeat (3) tick();
        PORT_i[13] = 1'b0;
        repeat (S + 1) tick();
        chk("th_hl_early", HL, 1'b1);
        tick();
        chk("th_hl_fall", HL, 1'b0);
        rd(4'd2, v);
        chk("th_hl_read_edge", HL, 1'b0);
        tick();
        chk("th_hl_cleared", HL, 1'b1);

        // Collision: read at the same edge a new fall sets PEND
        PORT_i[13] = 1'b1;
        repeat (4) tick();
        PORT_i[13] = 1'b0;
        repeat (S + 2) tick();
        chk("coll_pre", HL, 1'b0);
        PORT_i[13] = 1'b1;
        repeat (4) tick();
        PORT_i[13] = 1'b0;
        repeat (S) tick();
        rd(4'd2, v);
        chk("coll_hl0", HL, 1'b0);
        tick();
        chk("coll_hl1", HL, 1'b0);
        tick();
        chk("coll_hl2", HL, 1'b0);
        rd(4'd2, v);
        tick();
        chk("coll_clear", HL, 1'b1);

        // Masked pending on port 2 (pad bit 20)
        PORT_i[20] = 1'b0;
        repeat (S + 3) tick();
        chk("masked_hl", HL, 1'b1);
        wr(4'd6, 8'h80);
        chk("masked_wr_edge", HL, 1'b1);
        tick();
        chk("masked_fall", HL, 1'b0);
        wr(4'd6, 8'h00);
        wr(4'd5, 8'h00);
        tick();

        // Randomized traffic with occasional reset mid-access
        for (int i = 0; i < 3000; i++) begin
            CS    = ($urandom % 3 == 0);
            WE    = 1'($urandom);
            ADDR  = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 7);
            WDATA = 8'($urandom);
            if ($urandom % 4 == 0) begin
                PORT_i = N'($urandom);
            end else if ($urandom % 2 == 0) begin
                k = $urandom_range(N - 1);
                PORT_i[k] = ~PORT_i[k];
            end
            if ($urandom % 300 == 0) begin
                #2 SRES = 0;
                @(negedge MCLK);
                #1 SRES = 1;
            end else begin
                tick();
            end
        end
        CS = 0;
        WE = 0;
        tick();

        // 7x8 sweep with a walking one per port
        rd7(4'd0, v);
        chk("sweep_version", v, 8'h71);
        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < P7; p++)
                PI7[p*W7 +: W7] = 8'(1 << ((p + s) % 8));
            repeat (S) tick();
            for (int p = 0; p < P7; p++) begin
                e = 8'(1 << ((p + s) % 8));
                rd7(4'(p + 1), v);
                chk("sweep_data", v, e);
            end
        end
        rd7(4'd15, v);
        chk("sweep_addr15", v, 8'h00);
        chk("sweep_hl", HL7, 1'b1);
        chk("sweep_port_d", PD7, {N7{1'b1}});
        chk("sweep_port_o", PO7, {N7{1'b0}});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
